// File: rtl/seq_detect_stage.sv
// seq_detect_stage: serial sequence detector clocked entirely by inClk.
// slowClk is sampled as data and turned into a one-cycle sample tick; each
// tick shifts the synchronized serial bit into a history window and flags
// overlapping matches against PATTERN.
module seq_detect_stage #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic               inClk,
  input  logic               reset,
  input  logic               slowClk,
  input  logic               serialIn,
  input  logic               enable,
  input  logic               clearCount,
  output logic               matchPulse,
  output logic               matchLed,
  output logic [CNT_W-1:0]   matchCount,
  output logic [SEQ_LEN-1:0] window
);

  localparam int               FILL_W    = $clog2(SEQ_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Synchronizer and tick-generation registers
  logic       slow_meta_r;
  logic       slow_sync_r;
  logic       slow_prev_r;
  logic       ser_meta_r;
  logic       ser_sync_r;
  logic [1:0] settle_r;
  logic       armed_r;
  logic       tick_r;

  // Detector state and registered outputs
  state_t              state_r;
  logic [FILL_W-1:0]   fill_r;
  logic [SEQ_LEN-1:0]  window_r;
  logic                match_pulse_r;
  logic                match_led_r;
  logic [CNT_W-1:0]    match_count_r;

  // Combinational match evaluation
  logic [SEQ_LEN-1:0]  next_window_s;
  logic                full_s;
  logic                match_s;

  // Synchronize slowClk/serialIn, arm after a real low, and register the rising-edge tick.
  // settle_r flags when the sync chain has flushed its reset zeros, so a slowClk
  // held high across reset release is never mistaken for a fresh low.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      slow_meta_r <= 1'b0;
      slow_sync_r <= 1'b0;
      slow_prev_r <= 1'b0;
      ser_meta_r  <= 1'b0;
      ser_sync_r  <= 1'b0;
      settle_r    <= 2'b00;
      armed_r     <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      slow_meta_r <= slowClk;
      slow_sync_r <= slow_meta_r;
      slow_prev_r <= slow_sync_r;
      ser_meta_r  <= serialIn;
      ser_sync_r  <= ser_meta_r;
      settle_r    <= {settle_r[0], 1'b1};
      armed_r     <= armed_r | (settle_r[1] & ~slow_sync_r);
      tick_r      <= slow_sync_r & ~slow_prev_r & armed_r & enable;
    end
  end

  // Post-shift window and match decision; the FILL-to-RUN tick may already match.
  always_comb begin
    next_window_s = {window_r[SEQ_LEN-2:0], ser_sync_r};
    full_s        = 1'b0;
    match_s       = 1'b0;
    if ((state_r == ST_RUN) || (fill_r == FILL_LAST)) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (full_s && (next_window_s == PATTERN)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Detector FSM: shift on tick, track fill, drive pulse/LED/saturating counter.
  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_FILL;
      fill_r        <= '0;
      window_r      <= '0;
      match_pulse_r <= 1'b0;
      match_led_r   <= 1'b0;
      match_count_r <= '0;
    end else begin
      match_pulse_r <= 1'b0;
      if (tick_r) begin
        window_r      <= next_window_s;
        match_led_r   <= match_s;
        match_pulse_r <= match_s;
        case (state_r)
          ST_FILL: begin
            fill_r <= fill_r + FILL_ONE;
            if (fill_r == FILL_LAST) begin
              state_r <= ST_RUN;
            end else begin
              state_r <= ST_FILL;
            end
          end
          ST_RUN: begin
            state_r <= ST_RUN;
          end
          default: begin
            state_r <= ST_FILL;
            fill_r  <= '0;
          end
        endcase
      end
      // Clear takes priority over a same-cycle match increment.
      if (clearCount) begin
        match_count_r <= '0;
      end else if (tick_r && match_s && (match_count_r != CNT_MAX)) begin
        match_count_r <= match_count_r + CNT_ONE;
      end
    end
  end

  assign matchPulse = match_pulse_r;
  assign matchLed   = match_led_r;
  assign matchCount = match_count_r;
  assign window     = window_r;

endmodule

// File: doc/seq_detect_stage.md
Name: seq_detect_stage

Overview:
- Serial sequence detector that consumes the divided clock (slowClk) from the clock divider and a debounced switch bit (serialIn).
- Runs entirely in the inClk domain. slowClk is treated as a data signal: synchronized, then rising-edge detected into a one-cycle sample tick.
- On each tick, shifts one bit into a history window and flags overlapping matches against PATTERN.
- Drives LEDs: a match indicator, a saturating match counter and the current window.

Parameters:
- SEQ_LEN, 4, number of bits in the detected pattern (2..16).
- PATTERN, 4'b1011, pattern to detect; MSB is the oldest bit received.
- CNT_W, 8, width of the match counter.

Ports:
- inClk  input  1  system clock (100 MHz board oscillator).
- reset  input  1  asynchronous, active-high; clears all state.
- slowClk  input  1  divided clock from divider; asynchronous to this block's logic, sampled as data.
- serialIn  input  1  serial data bit; must be stable >=4 inClk cycles around each slowClk rising edge.
- enable  input  1  synchronous; 0 = ignore ticks.
- clearCount  input  1  synchronous; clears matchCount.
- matchPulse  output  1  one inClk-cycle pulse per detected match.
- matchLed  output  1  high from a matching tick until the next tick.
- matchCount  output  CNT_W  saturating count of matches.
- window  output  SEQ_LEN  current history window, newest bit in LSB.

Behaviour:
- Reset values: all outputs 0; sync flops 0; fill = 0; armed = 0; state = FILL.
- Synchronizers:
  - slowClk and serialIn each pass through a 2-flop synchronizer.
  - slowPrev holds the previous synchronized slowClk.
- Tick generation:
  - tick = slowS & ~slowPrev & armed & enable.
  - armed sets on the first cycle with slowS = 0 after reset and then stays 1. A slowClk held high through reset release therefore yields no tick until a genuine low-to-high edge.
- Latency:
  - slowClk first sampled high at inClk edge k → tick high between edges k+2 and k+3.
  - All tick-driven registers update at edge k+3.
  - The shifted bit is the synchronized serialIn value present during the tick cycle.
- State machine:
  - FILL: fewer than SEQ_LEN bits received since reset. fill increments per tick. No match is possible. On the tick making fill = SEQ_LEN → RUN.
  - RUN: window = {window[SEQ_LEN-2:0], bit} on each tick.
  - Match is evaluated on the post-shift window (next-window == PATTERN); it includes the transition tick from FILL.
  - Overlapping matches count: with PATTERN 1011, the stream 1011011 yields 2 matches.
- Match outputs on a matching tick (edge k+3):
  - matchPulse = 1 for exactly one inClk cycle.
  - matchLed = 1.
  - matchCount increments, saturating at 2^CNT_W-1 (no wrap).
- Non-matching tick: matchLed = 0; matchPulse stays 0.
- No tick: window, fill, state and matchLed hold; matchPulse = 0.
- enable = 0:
  - Ticks are suppressed; window, state and matchLed hold.
  - An edge occurring while disabled is lost, not deferred.
- clearCount:
  - Sets matchCount = 0 at the next edge.
  - If clearCount and a matching tick occur in the same cycle, clear wins: count = 0, while matchPulse and matchLed still assert.
- Reset mid-operation: asynchronously returns every register to its reset value, including a window partially filled in FILL state; detection restarts in FILL.
- Window: the window output reflects the shift register directly; bits not yet filled read 0.

Test Plan:
- Reset, slowClk held 1 across release, then 10 slowClk periods with serialIn = 0 → no tick until first real rise; window = 0000, matchCount = 0, matchPulse never asserts.
- serialIn stream 1,0,1,1 on successive rises → matchPulse one cycle, exactly 3 inClk edges after slowClk sampled high on the 4th rise; matchLed = 1, matchCount = 1; next rise with 0 → matchLed = 0.
- Overlap: stream 1,0,1,1,0,1,1 → two pulses (ticks 4 and 7), matchCount = 2, window = 1011 after tick 7.
- FILL guard: PATTERN = 4'b0000, reset, then serialIn = 0 → no match on ticks 1-3, first match on tick 4, then a match on every tick.
- Saturation/clear: CNT_W = 2 with 5 matches → count stops at 3. Assert clearCount in the same cycle as a matching tick → count = 0, matchPulse = 1.
- enable = 0 during two rises carrying 1,1, then enable = 1 → window unchanged across the disabled rises. Assert reset mid-stream → all outputs 0 immediately and state = FILL.
